// File: rtl/dbg_bus_reg_slave.sv
// ============================================================================
// dbg_bus_reg_slave : debug-bus register slave (ID/CTRL/STATUS/SCRATCH0..4)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dbg_bus_reg_slave #(
  parameter int          ADDR_WIDTH  = 15,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hDB60_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [31:0]           wdata,
  output logic                  gnt,
  output logic                  rvalid,
  output logic [31:0]           rdata,
  input  logic [31:0]           status_i,
  output logic [31:0]           ctrl_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [2:0] C_WAIT = 3'(WAIT_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [3:0]  w_idx;
  logic        w_gnt;
  logic [31:0] w_rd_val;
  logic [31:0] r_ctrl;
  logic [31:0] r_scratch [0:4];
  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        w_unused_addr;

  // Only addr[5:2] selects a register; the rest alias.
  assign w_idx         = addr[5:2];
  assign w_unused_addr = ^addr;

  assign w_gnt  = req && !rst && (r_cnt == C_WAIT);
  assign gnt    = w_gnt;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign ctrl_o = r_ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter reaches WAIT_CYCLES exactly N cycles after req first rises.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 3'd0;
        if (req && !w_gnt) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = 3'd1;
        end
      end
      ST_WAIT: begin
        if (!req || w_gnt) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_comb begin
    w_rd_val = 32'd0;
    case (w_idx)
      4'd0:    w_rd_val = ID_VALUE;
      4'd1:    w_rd_val = r_ctrl;
      4'd2:    w_rd_val = status_i;
      4'd3:    w_rd_val = r_scratch[0];
      4'd4:    w_rd_val = r_scratch[1];
      4'd5:    w_rd_val = r_scratch[2];
      4'd6:    w_rd_val = r_scratch[3];
      4'd7:    w_rd_val = r_scratch[4];
      default: w_rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= 32'd0;
      for (int i = 0; i < 5; i++) begin
        r_scratch[i] <= 32'd0;
      end
    end else if (w_gnt && we) begin
      case (w_idx)
        4'd1:    r_ctrl       <= wdata;
        4'd3:    r_scratch[0] <= wdata;
        4'd4:    r_scratch[1] <= wdata;
        4'd5:    r_scratch[2] <= wdata;
        4'd6:    r_scratch[3] <= wdata;
        4'd7:    r_scratch[4] <= wdata;
        default: ;
      endcase
    end
  end

  // rdata only moves on a grant, so it stays put between rvalid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_rvalid <= w_gnt;
      if (w_gnt) begin
        r_rdata <= we ? 32'd0 : w_rd_val;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dbg_bus_reg_slave.sv
// ============================================================================
// tb_dbg_bus_reg_slave : scoreboard bench, zero-wait and 3-wait instances
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dbg_bus_reg_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst0, req0, we0, gnt0, rvalid0;
  logic [14:0] addr0;
  logic [31:0] wdata0, rdata0, status0, ctrl0;

  logic        rst3, req3, we3, gnt3, rvalid3;
  logic [14:0] addr3;
  logic [31:0] wdata3, rdata3, status3, ctrl3;

  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q3 [$];

  dbg_bus_reg_slave #(.ADDR_WIDTH(15), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .req(req0), .addr(addr0), .we(we0), .wdata(wdata0),
    .gnt(gnt0), .rvalid(rvalid0), .rdata(rdata0), .status_i(status0), .ctrl_o(ctrl0)
  );

  dbg_bus_reg_slave #(.ADDR_WIDTH(15), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .req(req3), .addr(addr3), .we(we3), .wdata(wdata3),
    .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .status_i(status3), .ctrl_o(ctrl3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every rvalid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rvalid0) begin
      if (exp_q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rvalid0_unexpected: got rvalid=1 expected no response at %0t", $time);
      end else begin
        chk("rdata0", rdata0, exp_q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rvalid3) begin
      if (exp_q3.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rvalid3_unexpected: got rvalid=1 expected no response at %0t", $time);
      end else begin
        chk("rdata3", rdata3, exp_q3.pop_front());
      end
    end
  end

  // Tasks start and end just after a falling edge.
  task automatic tx0(input logic [14:0] a, input logic w, input logic [31:0] d,
                     input logic [31:0] exp);
    req0 = 1'b1; addr0 = a; we0 = w; wdata0 = d;
    exp_q0.push_back(exp);
    #1;
    chk("gnt0_zero_wait", {31'd0, gnt0}, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle0(input int n);
    req0 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic tx3(input logic [14:0] a, input logic w, input logic [31:0] d,
                     input logic [31:0] exp);
    int k;
    req3 = 1'b1; addr3 = a; we3 = w; wdata3 = d;
    exp_q3.push_back(exp);
    k = 0;
    #1;
    while (!gnt3 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("gnt3_wait_cycles", k, 32'd3);
    @(negedge clk);
  endtask

  task automatic idle3(input int n);
    req3 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst0 = 1'b1; req0 = 1'b1; addr0 = '0; we0 = 1'b0; wdata0 = '0; status0 = 32'hCAFE_0001;
    rst3 = 1'b1; req3 = 1'b0; addr3 = '0; we3 = 1'b0; wdata3 = '0; status3 = 32'h1234_5678;

    // ---------------- zero-wait instance ----------------
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_ctrl0", ctrl0, 32'd0);
    @(negedge clk);
    rst0 = 1'b0;

    tx0(15'h0000, 1'b0, 32'h0, 32'hDB60_0001);
    tx0(15'h0004, 1'b1, 32'hA5A5_0F0F, 32'h0);
    chk("ctrl0_after_write", ctrl0, 32'hA5A5_0F0F);
    tx0(15'h0004, 1'b0, 32'h0, 32'hA5A5_0F0F);
    tx0(15'h0044, 1'b0, 32'h0, 32'hA5A5_0F0F);
    tx0(15'h0000, 1'b1, 32'hFFFF_FFFF, 32'h0);
    tx0(15'h003C, 1'b1, 32'hFFFF_FFFF, 32'h0);
    tx0(15'h0000, 1'b0, 32'h0, 32'hDB60_0001);
    tx0(15'h003C, 1'b0, 32'h0, 32'h0);
    tx0(15'h0012, 1'b1, 32'h1111_2222, 32'h0);
    tx0(15'h0008, 1'b0, 32'h0, 32'hCAFE_0001);
    tx0(15'h0010, 1'b0, 32'h0, 32'h1111_2222);
    tx0(15'h000C, 1'b1, 32'hDEAD_BEEF, 32'h0);
    idle0(1);

    // Reset with a request pending: grant must be suppressed.
    rst0 = 1'b1; req0 = 1'b1; addr0 = 15'h000C; we0 = 1'b0;
    #1;
    chk("rst_pending_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_pending_rvalid0", {31'd0, rvalid0}, 32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    chk("post_rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("post_rst_ctrl0", ctrl0, 32'd0);
    tx0(15'h000C, 1'b0, 32'h0, 32'h0);
    tx0(15'h0004, 1'b0, 32'h0, 32'h0);
    idle0(3);

    // ---------------- three-wait instance ----------------
    @(negedge clk);
    rst3 = 1'b0;
    tx3(15'h0008, 1'b0, 32'h0, 32'h1234_5678);
    idle3(1);

    // Abort: request held two cycles then dropped.
    req3 = 1'b1; addr3 = 15'h0004; we3 = 1'b1; wdata3 = 32'h0000_0BAD;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("abort_gnt3", {31'd0, gnt3}, 32'd0);
      @(negedge clk);
    end
    idle3(2);
    chk("abort_ctrl3", ctrl3, 32'd0);
    tx3(15'h0004, 1'b0, 32'h0, 32'h0);
    tx3(15'h0004, 1'b1, 32'h5A5A_C3C3, 32'h0);
    tx3(15'h0004, 1'b0, 32'h0, 32'h5A5A_C3C3);
    chk("ctrl3_after_write", ctrl3, 32'h5A5A_C3C3);
    idle3(3);

    chk("q0_drained", exp_q0.size(), 32'd0);
    chk("q3_drained", exp_q3.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
